// File: rtl/pulse_handshake_rx.sv
// pulse_handshake_rx: clk1-side responder of a 4-phase req/ack handshake.
// Synchronises req_async, captures data_async into a one-entry valid/ready
// output register and returns ack as a registered level. Backpressure on the
// output delays ack, so a word is never overwritten before it is consumed.
// Optional feature: define PULSE_HS_RX_PARITY_EN to add even-parity checking
// (data_par_async in, rx_par_err out, registered alongside rx_data).
// SYNC_STAGES must lie in 2..4.
// nrst asserts asynchronously; its release is expected to be synchronous to clk1.

module pulse_handshake_rx #(
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk1,
  input  logic          nrst,
  input  logic          req_async,
  input  logic [DW-1:0] data_async,
`ifdef PULSE_HS_RX_PARITY_EN
  input  logic          data_par_async,
  output logic          rx_par_err,
`endif
  output logic          ack,
  output logic          rx_valid,
  output logic [DW-1:0] rx_data,
  input  logic          rx_ready,
  output logic          busy
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHold  = 2'd1,
    StAcked = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   ack_q, ack_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [DW-1:0]          rx_data_q, rx_data_d;
  logic                   slot_free;
  logic                   capture;

  assign req_s     = sync_q[SYNC_STAGES-1];
  // A slot drained in this very cycle is free for the next word.
  assign slot_free = !rx_valid_q || rx_ready;

  // Multi-flop synchroniser on the request level.
  always_ff @(posedge clk1 or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_async};
    end
  end

  // Handshake FSM next-state, ack level and capture strobe.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_s) begin
          if (slot_free) begin
            capture = 1'b1;
            ack_d   = 1'b1;
            state_d = StAcked;
          end else begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        // Request withdrawn before we could take it: abandon without capture.
        if (!req_s) begin
          state_d = StIdle;
        end else if (slot_free) begin
          capture = 1'b1;
          ack_d   = 1'b1;
          state_d = StAcked;
        end
      end
      StAcked: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // Output register next-state: capture wins over a same-cycle drain.
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    if (capture) begin
      rx_valid_d = 1'b1;
      rx_data_d  = data_async;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // State, ack and output word registers.
  always_ff @(posedge clk1 or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      ack_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

`ifdef PULSE_HS_RX_PARITY_EN
  logic par_err_q;

  // Parity error flag travels with the captured word.
  always_ff @(posedge clk1 or negedge nrst) begin
    if (!nrst) begin
      par_err_q <= 1'b0;
    end else if (capture) begin
      par_err_q <= ^{data_async, data_par_async};
    end
  end

  assign rx_par_err = par_err_q;
`endif

  assign ack      = ack_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_pulse_handshake_rx.sv
// Directed testbench for pulse_handshake_rx (DW=8, SYNC_STAGES=2).
// Inputs change on clk1 falling edges; outputs are sampled 1 ns after rising edges.
// Define PULSE_HS_RX_PARITY_EN to also exercise the parity option.

module tb_pulse_handshake_rx;

  logic       clk1 = 1'b0;
  logic       clk2 = 1'b0;
  logic       nrst;
  logic       req_async;
  logic [7:0] data_async;
  logic       ack;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       busy;
`ifdef PULSE_HS_RX_PARITY_EN
  logic       data_par_async;
  logic       rx_par_err;
`endif

  int checks = 0;
  int errors = 0;
  int t3_got;
  int t3_cyc;
  int t3_n;

  pulse_handshake_rx #(
    .DW          (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk1           (clk1),
    .nrst           (nrst),
    .req_async      (req_async),
    .data_async     (data_async),
`ifdef PULSE_HS_RX_PARITY_EN
    .data_par_async (data_par_async),
    .rx_par_err     (rx_par_err),
`endif
    .ack            (ack),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .busy           (busy)
  );

  always #5 clk1 = ~clk1;

  // Slow transmitter clock, clk1/5, phase-offset from clk1 edges.
  initial begin
    #2;
    forever #25 clk2 = ~clk2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  initial begin
    nrst       = 1'b0;
    req_async  = 1'b0;
    data_async = 8'h00;
    rx_ready   = 1'b0;
`ifdef PULSE_HS_RX_PARITY_EN
    data_par_async = 1'b0;
`endif
    #1;
    check("rst_ack", ack, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
`ifdef PULSE_HS_RX_PARITY_EN
    check("rst_par_err", rx_par_err, 0);
`endif
    @(negedge clk1);
    @(negedge clk1);
    nrst = 1'b1;

    // T1: basic transfer, latency 3 edges each way.
    @(negedge clk1);
    rx_ready = 1'b1; req_async = 1'b1; data_async = 8'hA5;
    step(2);
    check("t1_ack_early", ack, 0);
    check("t1_valid_early", rx_valid, 0);
    step(1);
    check("t1_ack", ack, 1);
    check("t1_valid", rx_valid, 1);
    check("t1_data", rx_data, 8'hA5);
    check("t1_busy", busy, 1);
    @(negedge clk1);
    req_async = 1'b0;
    step(2);
    check("t1_ack_hold", ack, 1);
    check("t1_valid_drained", rx_valid, 0);
    step(1);
    check("t1_ack_low", ack, 0);
    check("t1_busy_low", busy, 0);

    // T2: backpressure parks the FSM in HOLD without acking.
    @(negedge clk1);
    rx_ready = 1'b0; req_async = 1'b1; data_async = 8'h11;
    step(3);
    check("t2_first_data", rx_data, 8'h11);
    check("t2_first_ack", ack, 1);
    @(negedge clk1);
    req_async = 1'b0;
    step(3);
    check("t2_first_ack_low", ack, 0);
    check("t2_valid_kept", rx_valid, 1);
    @(negedge clk1);
    req_async = 1'b1; data_async = 8'h22;
    step(3);
    check("t2_hold_busy", busy, 1);
    check("t2_hold_ack", ack, 0);
    check("t2_hold_data", rx_data, 8'h11);
    step(2);
    check("t2_hold_busy2", busy, 1);
    check("t2_hold_ack2", ack, 0);
    @(negedge clk1);
    rx_ready = 1'b1;
    step(1);
    check("t2_cap_data", rx_data, 8'h22);
    check("t2_cap_ack", ack, 1);
    check("t2_cap_valid", rx_valid, 1);
    @(negedge clk1);
    rx_ready = 1'b0;
    step(1);
    check("t2_new_kept", rx_valid, 1);
    check("t2_new_data", rx_data, 8'h22);
    @(negedge clk1);
    req_async = 1'b0;
    step(3);
    check("t2_ack_low", ack, 0);
    @(negedge clk1);
    rx_ready = 1'b1;
    step(1);
    check("t2_drained", rx_valid, 0);

    // T3: 16 transfers from a clk2 transmitter, random consumer backpressure.
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          @(posedge clk2);
          data_async = i[7:0];
          req_async  = 1'b1;
          t3_n = 0;
          while (ack !== 1'b1 && t3_n < 200) begin
            @(posedge clk2);
            t3_n++;
          end
          check("t3_ack_rise", ack, 1);
          @(posedge clk2);
          req_async = 1'b0;
          t3_n = 0;
          while (ack !== 1'b0 && t3_n < 200) begin
            @(posedge clk2);
            t3_n++;
          end
          check("t3_ack_fall", ack, 0);
        end
      end
      begin
        t3_got = 0;
        t3_cyc = 0;
        while (t3_got < 16 && t3_cyc < 8000) begin
          @(negedge clk1);
          rx_ready = 1'($urandom_range(0, 1));
          // Accept happens on the coming rising edge.
          if (rx_valid && rx_ready) begin
            check("t3_word", rx_data, t3_got);
            t3_got++;
          end
          t3_cyc++;
        end
        check("t3_count", t3_got, 16);
      end
    join
    @(negedge clk1);
    rx_ready = 1'b1;
    step(4);
    check("t3_idle_valid", rx_valid, 0);
    check("t3_idle_busy", busy, 0);

    // T4: reset in ACKED, then a single fresh capture with req still high.
    @(negedge clk1);
    req_async = 1'b1; data_async = 8'h5A;
    step(3);
    check("t4_acked", ack, 1);
    @(negedge clk1);
    nrst = 1'b0;
    #1;
    check("t4_rst_ack", ack, 0);
    check("t4_rst_valid", rx_valid, 0);
    check("t4_rst_busy", busy, 0);
    @(negedge clk1);
    @(negedge clk1);
    nrst = 1'b1;
    step(2);
    check("t4_post_early", rx_valid, 0);
    step(1);
    check("t4_post_valid", rx_valid, 1);
    check("t4_post_data", rx_data, 8'h5A);
    check("t4_post_ack", ack, 1);
    step(5);
    check("t4_no_recapture", rx_valid, 0);
    check("t4_ack_held", ack, 1);
    @(negedge clk1);
    req_async = 1'b0;
    step(3);
    check("t4_ack_low", ack, 0);

    // T5: request withdrawn while in HOLD.
    @(negedge clk1);
    rx_ready = 1'b0; req_async = 1'b1; data_async = 8'h77;
    step(3);
    check("t5_fill", rx_data, 8'h77);
    @(negedge clk1);
    req_async = 1'b0;
    step(3);
    check("t5_fill_ack_low", ack, 0);
    @(negedge clk1);
    req_async = 1'b1; data_async = 8'h99;
    step(3);
    check("t5_hold_busy", busy, 1);
    @(negedge clk1);
    req_async = 1'b0;
    step(2);
    check("t5_still_hold", busy, 1);
    check("t5_ack_a", ack, 0);
    step(1);
    check("t5_idle", busy, 0);
    check("t5_ack_b", ack, 0);
    @(negedge clk1);
    rx_ready = 1'b1;
    step(1);
    check("t5_drained", rx_valid, 0);
    check("t5_data_kept", rx_data, 8'h77);
    step(3);
    check("t5_no_late_cap", rx_valid, 0);
    check("t5_ack_c", ack, 0);

`ifdef PULSE_HS_RX_PARITY_EN
    // T6: parity error flag registered at capture.
    @(negedge clk1);
    req_async = 1'b1; data_async = 8'h03; data_par_async = 1'b1;
    step(3);
    check("t6_err_data", rx_data, 8'h03);
    check("t6_err_set", rx_par_err, 1);
    @(negedge clk1);
    req_async = 1'b0;
    step(3);
    @(negedge clk1);
    req_async = 1'b1; data_par_async = 1'b0;
    step(3);
    check("t6_err_clr", rx_par_err, 0);
    check("t6_ack", ack, 1);
    @(negedge clk1);
    req_async = 1'b0;
    step(3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
